// File: rtl/calib_pkg.sv
// Shared definitions for the calibration pass controller.
// Contents:
//   - controller state encoding (state_t)
//   - corner field geometry (CORNER_W, NUM_CORNERS, CORNERS_W)
//   - corner_at(): unpacks corner i from the 80-bit {x0,y0,...,x3,y3} bus,
//     so that corner 0 sits in the top bits (x0 in [79:70]).
package calib_pkg;

  localparam int CORNER_W    = 10;
  localparam int NUM_CORNERS = 4;
  localparam int PAIR_W      = 2 * CORNER_W;
  localparam int CORNERS_W   = PAIR_W * NUM_CORNERS;

  typedef logic [CORNER_W-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } corner_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FRAME,
    START_CD,
    WAIT_CD,
    CHECK,
    KICK_XF,
    WAIT_XF,
    FAIL
  } state_t;

  // Corner 0 occupies the most significant pair, so the slice walks down.
  function automatic corner_t corner_at(input logic [CORNERS_W-1:0] c, input int i);
    return c[CORNERS_W-1-(i*PAIR_W) -: PAIR_W];
  endfunction

endpackage

// File: rtl/corner_bounds_check.sv
// Sanity checker for four packed corners.
// Passes when every x <= X_MAX, every y <= Y_MAX and both the x and y
// extents (max - min) are at least MIN_SPAN. The verdict is registered, so
// `pass` reflects the `corners` value presented one cycle earlier.
// Ports:
//   clk      in  1   clock
//   reset_n  in  1   asynchronous active-low reset
//   corners  in  80  {x0,y0,x1,y1,x2,y2,x3,y3}
//   pass     out 1   registered check result
module corner_bounds_check
  import calib_pkg::*;
#(
  parameter int X_MAX    = 1023,
  parameter int Y_MAX    = 767,
  parameter int MIN_SPAN = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [CORNERS_W-1:0] corners,
  output logic                 pass
);

  // Limits carry one extra bit so a limit equal to the field maximum still
  // yields a real comparison rather than a constant one.
  localparam logic [CORNER_W:0] X_LIM    = (CORNER_W+1)'(X_MAX);
  localparam logic [CORNER_W:0] Y_LIM    = (CORNER_W+1)'(Y_MAX);
  localparam coord_t            SPAN_MIN = coord_t'(MIN_SPAN);

  coord_t [NUM_CORNERS-1:0] xs;
  coord_t [NUM_CORNERS-1:0] ys;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CORNERS; gi++) begin : g_unpack
      corner_t c;
      assign c      = corner_at(corners, gi);
      assign xs[gi] = c.x;
      assign ys[gi] = c.y;
    end
  endgenerate

  coord_t x_min, x_max, y_min, y_max;
  coord_t x_span, y_span;
  logic   in_range;
  logic   pass_next;

  always_comb begin
    x_min    = xs[0];
    x_max    = xs[0];
    y_min    = ys[0];
    y_max    = ys[0];
    in_range = 1'b1;
    for (int i = 0; i < NUM_CORNERS; i++) begin
      if (xs[i] < x_min) x_min = xs[i];
      if (xs[i] > x_max) x_max = xs[i];
      if (ys[i] < y_min) y_min = ys[i];
      if (ys[i] > y_max) y_max = ys[i];
      if (({1'b0, xs[i]} > X_LIM) || ({1'b0, ys[i]} > Y_LIM)) in_range = 1'b0;
    end
    // max >= min by construction, so the unsigned difference never wraps.
    x_span    = x_max - x_min;
    y_span    = y_max - y_min;
    pass_next = in_range && (x_span >= SPAN_MIN) && (y_span >= SPAN_MIN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pass <= 1'b0;
    end else begin
      pass <= pass_next;
    end
  end

endmodule

// File: rtl/calibration_controller.sv
// Sequences one projector/camera calibration pass.
// Waits for a frame boundary, pulses the corner detector, waits (with
// timeout) for its result, checks the corners and, if they are sane, starts
// the perspective transform and waits for it. Bad or missing results are
// retried up to MAX_RETRY times before the sticky error flag is raised.
// Ports:
//   clk            in  1   clock
//   reset_n        in  1   asynchronous active-low reset
//   calibrate      in  1   run request (rising edge starts a run)
//   frame_start    in  1   vertical-blank pulse
//   cd_start       out 1   corner detector start pulse
//   cd_done        in  1   corner detector done pulse
//   cd_corners     in  80  detected corners {x0,y0,...,x3,y3}
//   xf_start       out 1   transform start pulse
//   xf_done        in  1   transform done pulse
//   corners_q      out 80  latched corners
//   corners_valid  out 1   corners_q passed the check
//   busy           out 1   run in progress (not IDLE / FAIL)
//   error          out 1   sticky failure flag
//   attempts       out 2   detection attempts of current/last run (sat. 3)
module calibration_controller
  import calib_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1048575,
  parameter int MAX_RETRY   = 3,
  parameter int X_MAX       = 1023,
  parameter int Y_MAX       = 767,
  parameter int MIN_SPAN    = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 calibrate,
  input  logic                 frame_start,
  output logic                 cd_start,
  input  logic                 cd_done,
  input  logic [CORNERS_W-1:0] cd_corners,
  output logic                 xf_start,
  input  logic                 xf_done,
  output logic [CORNERS_W-1:0] corners_q,
  output logic                 corners_valid,
  output logic                 busy,
  output logic                 error,
  output logic [1:0]           attempts
);

  localparam logic [19:0] TMO_LIM   = 20'(TIMEOUT_CYC);
  localparam logic [7:0]  RETRY_LIM = 8'(MAX_RETRY);

  state_t                 state_reg, state_next;
  logic [19:0]            tmo_reg, tmo_next;
  logic [7:0]             retry_reg, retry_next;
  logic [1:0]             attempts_reg, attempts_next;
  logic [CORNERS_W-1:0]   corners_reg, corners_next;
  logic                   valid_reg, valid_next;
  logic                   error_reg, error_next;
  logic                   cal_prev_reg;
  logic                   cal_rise;
  logic                   check_pass;
  logic                   retry_req;

  // The checker samples the detector bus every cycle; in CHECK its
  // registered verdict refers to the corners latched on the cd_done cycle.
  corner_bounds_check #(
    .X_MAX    (X_MAX),
    .Y_MAX    (Y_MAX),
    .MIN_SPAN (MIN_SPAN)
  ) u_check (
    .clk     (clk),
    .reset_n (reset_n),
    .corners (cd_corners),
    .pass    (check_pass)
  );

  assign cal_rise = calibrate & ~cal_prev_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      tmo_reg      <= '0;
      retry_reg    <= '0;
      attempts_reg <= '0;
      corners_reg  <= '0;
      valid_reg    <= 1'b0;
      error_reg    <= 1'b0;
      cal_prev_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tmo_reg      <= tmo_next;
      retry_reg    <= retry_next;
      attempts_reg <= attempts_next;
      corners_reg  <= corners_next;
      valid_reg    <= valid_next;
      error_reg    <= error_next;
      cal_prev_reg <= calibrate;
    end
  end

  always_comb begin
    state_next    = state_reg;
    tmo_next      = tmo_reg;
    retry_next    = retry_reg;
    attempts_next = attempts_reg;
    corners_next  = corners_reg;
    valid_next    = valid_reg;
    error_next    = error_reg;
    retry_req     = 1'b0;

    case (state_reg)
      // A rising edge in FAIL starts a fresh run directly.
      IDLE, FAIL: begin
        if (cal_rise) begin
          state_next    = WAIT_FRAME;
          valid_next    = 1'b0;
          error_next    = 1'b0;
          attempts_next = '0;
          retry_next    = '0;
        end
      end
      WAIT_FRAME: begin
        if (frame_start) state_next = START_CD;
      end
      START_CD: begin
        tmo_next = '0;
        if (attempts_reg != 2'd3) attempts_next = attempts_reg + 2'd1;
        state_next = WAIT_CD;
      end
      WAIT_CD: begin
        // done takes priority over a timeout on the same cycle
        if (cd_done) begin
          corners_next = cd_corners;
          state_next   = CHECK;
        end else if (tmo_reg == TMO_LIM) begin
          retry_req = 1'b1;
        end else begin
          tmo_next = tmo_reg + 20'd1;
        end
      end
      CHECK: begin
        if (check_pass) begin
          valid_next = 1'b1;
          state_next = KICK_XF;
        end else begin
          retry_req = 1'b1;
        end
      end
      KICK_XF: begin
        tmo_next   = '0;
        state_next = WAIT_XF;
      end
      WAIT_XF: begin
        if (xf_done) begin
          state_next = IDLE;
        end else if (tmo_reg == TMO_LIM) begin
          state_next = FAIL;
          error_next = 1'b1;
        end else begin
          tmo_next = tmo_reg + 20'd1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (retry_req) begin
      if (retry_reg < RETRY_LIM) begin
        retry_next = retry_reg + 8'd1;
        state_next = WAIT_FRAME;
      end else begin
        state_next = FAIL;
        error_next = 1'b1;
      end
    end
  end

  // Pulses are decoded from single-cycle states, so they can never overlap
  // or stretch, and an asynchronous reset cuts them immediately.
  assign cd_start      = (state_reg == START_CD);
  assign xf_start      = (state_reg == KICK_XF);
  assign busy          = (state_reg != IDLE) && (state_reg != FAIL);
  assign corners_q     = corners_reg;
  assign corners_valid = valid_reg;
  assign error         = error_reg;
  assign attempts      = attempts_reg;

endmodule
